// File: rtl/axi_pwm_multi.sv
// AXI4-Lite multi-channel PWM: shared prescaler, per-channel edge/center counting, shadowed period/duty.
// Optional interrupt block (IRQ_STATUS/IRQ_MASK, irq output) is compiled in with `define PWM_IRQ_EN.
module axi_pwm_multi #(
   parameter int AXI_ADDR_WIDTH  = 6,
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int NUM_CHANNELS    = 8,
   parameter int REG_WIDTH       = 16,
   parameter int PRESCALER_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      axi_awvalid,
   output logic                      axi_awready,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
   input  logic                      axi_wvalid,
   output logic                      axi_wready,
   input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
   output logic                      axi_bvalid,
   input  logic                      axi_bready,
   input  logic                      axi_arvalid,
   output logic                      axi_arready,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
   output logic                      axi_rvalid,
   input  logic                      axi_rready,
   output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
   input  logic                      pwm_enable,
   output logic [NUM_CHANNELS-1:0]   pwm_out,
   output logic                      irq
);
   localparam int CH_BASE = 4;
   localparam int CH_IW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_PRESCALE = AXI_ADDR_WIDTH'(0);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_GCTRL    = AXI_ADDR_WIDTH'(1);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_IRQ_STAT = AXI_ADDR_WIDTH'(2);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_IRQ_MASK = AXI_ADDR_WIDTH'(3);

   logic                       awready_r, bvalid_r, arready_r, rvalid_r, irq_r;
   logic [AXI_DATA_WIDTH-1:0]  rdata_r, rd_data_s;
   logic [PRESCALER_WIDTH-1:0] prescale_r, pre_cnt_r;
   logic                       global_en_r;
   logic [NUM_CHANNELS-1:0]    ch_en_r, ch_center_r, ch_inv_r, dir_down_r, boundary_s, pwm_r;
   logic [REG_WIDTH-1:0]       period_r [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]       duty_r [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]       period_sh_r [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]       duty_sh_r [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]       cnt_r [NUM_CHANNELS];
   logic                       wr_en_s, force_upd_s, run_s, tick_s;
   logic                       wr_ch_sel_s, rd_ch_sel_s, unused_wdata_s;
   logic [CH_IW-1:0]           wr_ch_s, rd_ch_s;
   logic [1:0]                 wr_fld_s, rd_fld_s;
   int                         wr_off_s, rd_off_s;

   assign axi_awready = awready_r;
   assign axi_wready  = awready_r;
   assign axi_bvalid  = bvalid_r;
   assign axi_arready = arready_r;
   assign axi_rvalid  = rvalid_r;
   assign axi_rdata   = rdata_r;
   assign pwm_out     = pwm_r;
   assign irq         = irq_r;

   assign wr_en_s        = awready_r & axi_awvalid & axi_wvalid;
   assign force_upd_s    = wr_en_s & (axi_awaddr == ADDR_GCTRL) & axi_wdata[1];
   assign run_s          = pwm_enable & global_en_r;
   assign tick_s         = run_s & (pre_cnt_r >= prescale_r);
   assign unused_wdata_s = ^axi_wdata;

   // Channel registers sit at 4+3i; split the word index into channel and field
   assign wr_off_s    = int'(axi_awaddr) - CH_BASE;
   assign wr_ch_sel_s = (wr_off_s >= 0) && (wr_off_s < 3 * NUM_CHANNELS);
   assign wr_ch_s     = CH_IW'(wr_off_s / 3);
   assign wr_fld_s    = 2'(wr_off_s % 3);
   assign rd_off_s    = int'(axi_araddr) - CH_BASE;
   assign rd_ch_sel_s = (rd_off_s >= 0) && (rd_off_s < 3 * NUM_CHANNELS);
   assign rd_ch_s     = CH_IW'(rd_off_s / 3);
   assign rd_fld_s    = 2'(rd_off_s % 3);

   // AXI handshakes: one-cycle ready pulses, valid held until the master takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awready_r <= 1'b0;
         bvalid_r  <= 1'b0;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= '0;
      end else begin
         awready_r <= axi_awvalid & axi_wvalid & ~bvalid_r & ~awready_r;
         if (wr_en_s) begin
            bvalid_r <= 1'b1;
         end else if (axi_bready) begin
            bvalid_r <= 1'b0;
         end
         arready_r <= axi_arvalid & ~rvalid_r & ~arready_r;
         if (arready_r && axi_arvalid) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
         end else if (axi_rready) begin
            rvalid_r <= 1'b0;
         end
      end
   end

   // Register file writes on the write-handshake edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_r  <= '0;
         global_en_r <= 1'b0;
         ch_en_r     <= '0;
         ch_center_r <= '0;
         ch_inv_r    <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            period_r[i] <= '0;
            duty_r[i]   <= '0;
         end
      end else if (wr_en_s) begin
         if (axi_awaddr == ADDR_PRESCALE) begin
            prescale_r <= axi_wdata[PRESCALER_WIDTH-1:0];
         end else if (axi_awaddr == ADDR_GCTRL) begin
            global_en_r <= axi_wdata[0];
         end else if (wr_ch_sel_s) begin
            case (wr_fld_s)
               2'd0: begin
                  ch_en_r[wr_ch_s]     <= axi_wdata[0];
                  ch_center_r[wr_ch_s] <= axi_wdata[1];
                  ch_inv_r[wr_ch_s]    <= axi_wdata[2];
               end
               2'd1:    period_r[wr_ch_s] <= axi_wdata[REG_WIDTH-1:0];
               2'd2:    duty_r[wr_ch_s]   <= axi_wdata[REG_WIDTH-1:0];
               default: ;
            endcase
         end
      end
   end

`ifdef PWM_IRQ_EN
   logic [NUM_CHANNELS-1:0] irq_status_r, irq_mask_r, irq_clr_s;
   assign irq_clr_s = (wr_en_s && axi_awaddr == ADDR_IRQ_STAT) ? axi_wdata[NUM_CHANNELS-1:0] : '0;

   // W1C status with set priority; irq is the registered OR of masked status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_status_r <= '0;
         irq_mask_r   <= '0;
         irq_r        <= 1'b0;
      end else begin
         irq_status_r <= (irq_status_r & ~irq_clr_s) | boundary_s;
         if (wr_en_s && axi_awaddr == ADDR_IRQ_MASK) begin
            irq_mask_r <= axi_wdata[NUM_CHANNELS-1:0];
         end
         irq_r <= |(irq_status_r & irq_mask_r);
      end
   end
`else
   // Interrupt logic absent: irq stays low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= 1'b0;
      end
   end
`endif

   // Read mux; PERIOD/DUTY return the programmed value, not the live shadow
   always_comb begin
      rd_data_s = '0;
      if (axi_araddr == ADDR_PRESCALE) begin
         rd_data_s = AXI_DATA_WIDTH'(prescale_r);
      end else if (axi_araddr == ADDR_GCTRL) begin
         rd_data_s = AXI_DATA_WIDTH'(global_en_r);
`ifdef PWM_IRQ_EN
      end else if (axi_araddr == ADDR_IRQ_STAT) begin
         rd_data_s = AXI_DATA_WIDTH'(irq_status_r);
      end else if (axi_araddr == ADDR_IRQ_MASK) begin
         rd_data_s = AXI_DATA_WIDTH'(irq_mask_r);
`endif
      end else if (rd_ch_sel_s) begin
         case (rd_fld_s)
            2'd0:    rd_data_s = AXI_DATA_WIDTH'({ch_inv_r[rd_ch_s], ch_center_r[rd_ch_s], ch_en_r[rd_ch_s]});
            2'd1:    rd_data_s = AXI_DATA_WIDTH'(period_r[rd_ch_s]);
            2'd2:    rd_data_s = AXI_DATA_WIDTH'(duty_r[rd_ch_s]);
            default: rd_data_s = '0;
         endcase
      end else begin
         rd_data_s = '0;
      end
   end

   // Shared prescaler, held at zero while not running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_r <= '0;
      end else if (!run_s || tick_s) begin
         pre_cnt_r <= '0;
      end else begin
         pre_cnt_r <= pre_cnt_r + PRESCALER_WIDTH'(1);
      end
   end

   // Period boundary per channel
   always_comb begin
      boundary_s = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (!tick_s || !ch_en_r[i]) begin
            boundary_s[i] = 1'b0;
         end else if (period_sh_r[i] == '0) begin
            boundary_s[i] = 1'b1;
         end else if (ch_center_r[i]) begin
            boundary_s[i] = dir_down_r[i] & (cnt_r[i] == '0);
         end else begin
            boundary_s[i] = cnt_r[i] >= period_sh_r[i];
         end
      end
   end

   // Counters, shadows and outputs. Center mode holds each end value for two ticks
   // (0..P-1, P-1..0) so the active window is symmetric: 2*duty ticks of a 2*period cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_down_r <= '0;
         pwm_r      <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_r[i]       <= '0;
            period_sh_r[i] <= '0;
            duty_sh_r[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!ch_en_r[i] || !run_s) begin
               cnt_r[i]      <= '0;
               dir_down_r[i] <= 1'b0;
            end else if (tick_s) begin
               if (period_sh_r[i] == '0) begin
                  cnt_r[i]      <= '0;
                  dir_down_r[i] <= 1'b0;
               end else if (!ch_center_r[i]) begin
                  cnt_r[i]      <= boundary_s[i] ? '0 : cnt_r[i] + REG_WIDTH'(1);
                  dir_down_r[i] <= 1'b0;
               end else if (!dir_down_r[i]) begin
                  if (cnt_r[i] >= period_sh_r[i] - REG_WIDTH'(1)) begin
                     dir_down_r[i] <= 1'b1;
                  end else begin
                     cnt_r[i] <= cnt_r[i] + REG_WIDTH'(1);
                  end
               end else if (cnt_r[i] == '0) begin
                  dir_down_r[i] <= 1'b0;
               end else begin
                  cnt_r[i] <= cnt_r[i] - REG_WIDTH'(1);
               end
            end
            if (boundary_s[i] || force_upd_s || !ch_en_r[i]) begin
               period_sh_r[i] <= period_r[i];
               duty_sh_r[i]   <= duty_r[i];
            end
            pwm_r[i] <= ((cnt_r[i] < duty_sh_r[i]) & ch_en_r[i] & run_s) ^ ch_inv_r[i];
         end
      end
   end
endmodule

// File: tb/tb_axi_pwm_multi.sv
// Directed self-checking bench for axi_pwm_multi: bus handshakes, register map, PWM timing, reset.
module tb_axi_pwm_multi;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        axi_awvalid = 1'b0, axi_wvalid = 1'b0, axi_bready = 1'b1;
   logic        axi_arvalid = 1'b0, axi_rready = 1'b1, pwm_enable = 1'b0;
   logic [5:0]  axi_awaddr = 6'd0, axi_araddr = 6'd0;
   logic [31:0] axi_wdata = 32'd0;
   logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, irq;
   logic [31:0] axi_rdata;
   logic [7:0]  pwm_out;
   int          compared = 0, mismatched = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_pwm_multi dut (
      .clk(clk), .rst(rst),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .pwm_enable(pwm_enable), .pwm_out(pwm_out), .irq(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_awready(input string tag);
      int n = 0;
      while (axi_awready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(axi_awready), 32'd1);
   endtask

   task automatic finish_write();
      int n = 0;
      @(posedge clk);
      #1;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      while (axi_bvalid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bvalid", 32'(axi_bvalid), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data);
      axi_awaddr  = addr;
      axi_wdata   = data;
      axi_awvalid = 1'b1;
      axi_wvalid  = 1'b1;
      wait_awready($sformatf("awready@%0d", addr));
      finish_write();
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
      int n = 0;
      axi_araddr  = addr;
      axi_arvalid = 1'b1;
      while (axi_arready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("arready", 32'(axi_arready), 32'd1);
      @(posedge clk);
      #1;
      axi_arvalid = 1'b0;
      n = 0;
      while (axi_rvalid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rvalid", 32'(axi_rvalid), 32'd1);
      data = axi_rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_level(input int ch, input logic lvl, output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pwm_out[ch] !== lvl && n < 2000);
      check($sformatf("wait pwm%0d=%0b", ch, lvl), 32'(pwm_out[ch]), 32'(lvl));
      t = cyc;
   endtask

   task automatic count_high(input int ch, input int ncyc, output int ones);
      ones = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (pwm_out[ch] === 1'b1) ones++;
      end
   endtask

   initial begin
      logic [31:0] d;
      int t0, t1, t2, t3, t4, t5, t6, n;

      repeat (3) @(negedge clk);
      check("rst_hs", 32'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, irq}), 32'd0);
      check("rst_rdata", axi_rdata, 32'd0);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      axi_read(6'd5, d);
      check("period0_after_rst", d, 32'd0);

      // ch0 edge mode, 10-clock tick, period 20 ticks, duty 10 ticks
      pwm_enable = 1'b1;
      axi_write(6'd0, 32'd9);
      axi_write(6'd5, 32'd19);
      axi_write(6'd6, 32'd10);
      axi_write(6'd4, 32'd1);
      axi_write(6'd1, 32'd3);
      axi_read(6'd1, d);
      check("gctrl_rd", d, 32'd1);
      axi_read(6'd0, d);
      check("prescale_rd", d, 32'd9);
      wait_level(0, 1'b0, t0);
      wait_level(0, 1'b1, t0);
      wait_level(0, 1'b0, t1);
      wait_level(0, 1'b1, t2);
      check("edge_high", 32'(t1 - t0), 32'd100);
      check("edge_low", 32'(t2 - t1), 32'd100);

      // Duty change mid-period takes effect at the next boundary
      axi_write(6'd6, 32'd15);
      wait_level(0, 1'b0, t3);
      wait_level(0, 1'b1, t4);
      wait_level(0, 1'b0, t5);
      wait_level(0, 1'b1, t6);
      check("old_duty_high", 32'(t3 - t2), 32'd100);
      check("old_duty_low", 32'(t4 - t3), 32'd100);
      check("new_duty_high", 32'(t5 - t4), 32'd150);
      check("new_duty_low", 32'(t6 - t5), 32'd50);
      axi_read(6'd6, d);
      check("duty_rd", d, 32'd15);
      axi_write(6'd6, 32'd0);
      repeat (250) @(negedge clk);
      count_high(0, 220, n);
      check("duty0_ones", 32'(n), 32'd0);
      axi_write(6'd6, 32'd20);
      repeat (250) @(negedge clk);
      count_high(0, 220, n);
      check("duty_over_ones", 32'(n), 32'd220);

      // ch1 center mode, inverted, tick every clock
      axi_write(6'd0, 32'd0);
      axi_write(6'd8, 32'd4);
      axi_write(6'd9, 32'd2);
      axi_write(6'd7, 32'd7);
      wait_level(1, 1'b1, t0);
      wait_level(1, 1'b0, t1);
      wait_level(1, 1'b1, t2);
      wait_level(1, 1'b0, t3);
      check("center_low", 32'(t2 - t1), 32'd4);
      check("center_high", 32'(t3 - t2), 32'd4);
      axi_write(6'd7, 32'd6);
      repeat (3) @(negedge clk);
      count_high(1, 20, n);
      check("disabled_inverted", 32'(n), 32'd20);

      // Second write blocked while the first response is outstanding
      axi_bready  = 1'b0;
      axi_awaddr  = 6'd11;
      axi_wdata   = 32'd7;
      axi_awvalid = 1'b1;
      axi_wvalid  = 1'b1;
      wait_awready("b2b_first");
      @(posedge clk);
      #1;
      axi_awaddr = 6'd12;
      axi_wdata  = 32'd3;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (axi_awready === 1'b1) n++;
      end
      check("b2b_blocked", 32'(n), 32'd0);
      check("b2b_bvalid_held", 32'(axi_bvalid), 32'd1);
      axi_bready = 1'b1;
      wait_awready("b2b_second");
      finish_write();
      axi_read(6'd11, d);
      check("period2_rd", d, 32'd7);
      axi_read(6'd12, d);
      check("duty2_rd", d, 32'd3);
      axi_read(6'd63, d);
      check("unmapped_rd", d, 32'd0);

`ifdef PWM_IRQ_EN
      axi_write(6'd3, 32'd1);
      n = 0;
      while (irq !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("irq_rise", 32'(irq), 32'd1);
      axi_write(6'd4, 32'd0);
      axi_write(6'd2, 32'd1);
      check("irq_cleared", 32'(irq), 32'd0);
      axi_write(6'd4, 32'd1);
`else
      axi_write(6'd3, 32'd1);
      axi_read(6'd3, d);
      check("irq_mask_absent", d, 32'd0);
      count_high(0, 50, n);
      check("ch0_running", 32'(n), 32'd50);
      n = 0;
      repeat (50) begin
         @(negedge clk);
         if (irq !== 1'b0) n++;
      end
      check("irq_tied_low", 32'(n), 32'd0);
`endif

      // Hardware run gate forces outputs to their idle (invert) level
      pwm_enable = 1'b0;
      repeat (2) @(negedge clk);
      check("run_off_idle", 32'(pwm_out), 32'h02);
      pwm_enable = 1'b1;
      repeat (5) @(negedge clk);
      check("run_on", 32'(pwm_out), 32'h03);

      // Asynchronous reset in the middle of a write handshake
      axi_awaddr  = 6'd5;
      axi_wdata   = 32'd123;
      axi_awvalid = 1'b1;
      axi_wvalid  = 1'b1;
      wait_awready("rst_mid_aw");
      rst = 1'b1;
      #1;
      check("rst_mid_hs", 32'({axi_awready, axi_wready, axi_bvalid}), 32'd0);
      check("rst_mid_pwm", 32'(pwm_out), 32'd0);
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      axi_read(6'd5, d);
      check("period0_after_mid_rst", d, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
